rtp_depacketizer: RTL and testbench

RTP_DEPACKETIZER -- requirements
Module: rtp_depacketizer

---
 rtl/rtp_depacketizer.sv | 198 +++++++++++++++++++
 tb/tb_rtp_depacketizer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rtp_depacketizer.sv
// RTP/PCM depacketizer: validates the 12-byte RTP header of each UDP payload,
// streams 16-bit big-endian samples to a playback FIFO and tracks sequence loss.
module rtp_depacketizer #(
    parameter logic [6:0]  PT_EXPECT   = 7'd0,
    parameter logic [31:0] SSRC_EXPECT = 32'h12345678,
    parameter logic [15:0] MAX_LEN     = 16'd972
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               udp_rec_data_valid,
    input  logic [7:0]         udp_rec_rdata,
    input  logic [15:0]        udp_rec_data_length,
    input  logic               wav_out_full,
    output logic signed [15:0] wav_out_data,
    output logic               wav_out_wren,
    output logic [15:0]        rtp_seq,
    output logic [31:0]        rtp_timestamp,
    output logic               pkt_ok,
    output logic               pkt_drop,
    output logic [15:0]        lost_count,
    output logic [15:0]        overflow_count
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DISCARD} state_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    function automatic logic [7:0] ssrc_byte(input logic [1:0] k);
        case (k)
            2'd0:    return SSRC_EXPECT[31:24];
            2'd1:    return SSRC_EXPECT[23:16];
            2'd2:    return SSRC_EXPECT[15:8];
            default: return SSRC_EXPECT[7:0];
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [15:0]        byte_cnt_q, byte_cnt_d;
    logic [15:0]        len_q, len_d;
    logic [15:0]        seq_c_q, seq_c_d;
    logic [31:0]        ts_c_q, ts_c_d;
    logic [7:0]         hi_q, hi_d;
    logic               ref_valid_q, ref_valid_d;
    logic signed [15:0] wav_out_data_q, wav_out_data_d;
    logic               wav_out_wren_q, wav_out_wren_d;
    logic [15:0]        rtp_seq_q, rtp_seq_d;
    logic [31:0]        rtp_timestamp_q, rtp_timestamp_d;
    logic               pkt_ok_q, pkt_ok_d;
    logic               pkt_drop_q, pkt_drop_d;
    logic [15:0]        lost_count_q, lost_count_d;
    logic [15:0]        overflow_count_q, overflow_count_d;

    logic [15:0] idx;
    logic [15:0] len_cur;
    logic        last_byte;
    logic        len_bad;
    logic        hdr_fail;
    logic        fin_good;
    logic        fin_drop;

    always_comb begin
        idx       = (state_q == S_IDLE) ? 16'd0 : byte_cnt_q + 16'd1;
        len_cur   = (state_q == S_IDLE) ? udp_rec_data_length : len_q;
        // A zero length still consumes the single byte that carried it.
        last_byte = (len_cur == 16'd0) ? (idx == 16'd0) : (idx == len_cur - 16'd1);
        len_bad   = (udp_rec_data_length < 16'd12) || (udp_rec_data_length > MAX_LEN) ||
                    udp_rec_data_length[0];

        state_d          = state_q;
        byte_cnt_d       = byte_cnt_q;
        len_d            = len_q;
        seq_c_d          = seq_c_q;
        ts_c_d           = ts_c_q;
        hi_d             = hi_q;
        ref_valid_d      = ref_valid_q;
        wav_out_data_d   = wav_out_data_q;
        wav_out_wren_d   = 1'b0;
        rtp_seq_d        = rtp_seq_q;
        rtp_timestamp_d  = rtp_timestamp_q;
        pkt_ok_d         = 1'b0;
        pkt_drop_d       = 1'b0;
        lost_count_d     = lost_count_q;
        overflow_count_d = overflow_count_q;
        hdr_fail         = 1'b0;
        fin_good         = 1'b0;
        fin_drop         = 1'b0;

        if (udp_rec_data_valid) begin
            byte_cnt_d = idx;
            case (state_q)
                S_IDLE: begin
                    len_d    = udp_rec_data_length;
                    hdr_fail = len_bad || (udp_rec_rdata != 8'h80);
                    if (last_byte)     fin_drop = 1'b1;
                    else if (hdr_fail) state_d  = S_DISCARD;
                    else               state_d  = S_HDR;
                end
                S_HDR: begin
                    if (idx == 16'd1)
                        hdr_fail = (udp_rec_rdata[6:0] != PT_EXPECT);
                    else if (idx >= 16'd8)
                        hdr_fail = (udp_rec_rdata != ssrc_byte(idx[1:0]));
                    if (idx == 16'd2 || idx == 16'd3)
                        seq_c_d = {seq_c_q[7:0], udp_rec_rdata};
                    if (idx >= 16'd4 && idx <= 16'd7)
                        ts_c_d = {ts_c_q[23:0], udp_rec_rdata};
                    if (last_byte) begin
                        fin_good = ~hdr_fail;
                        fin_drop = hdr_fail;
                    end else if (hdr_fail) begin
                        state_d = S_DISCARD;
                    end else if (idx == 16'd11) begin
                        state_d = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    // Payload starts at an even offset, so even bytes are sample high halves.
                    if (!idx[0]) begin
                        hi_d = udp_rec_rdata;
                    end else if (wav_out_full) begin
                        overflow_count_d = sat_add16(overflow_count_q, 16'd1);
                    end else begin
                        wav_out_data_d = $signed({hi_q, udp_rec_rdata});
                        wav_out_wren_d = 1'b1;
                    end
                    if (last_byte) fin_good = 1'b1;
                end
                default: begin
                    if (last_byte) fin_drop = 1'b1;
                end
            endcase
        end

        if (fin_good) begin
            state_d         = S_IDLE;
            pkt_ok_d        = 1'b1;
            rtp_seq_d       = seq_c_q;
            rtp_timestamp_d = ts_c_q;
            ref_valid_d     = 1'b1;
            if (ref_valid_q)
                lost_count_d = sat_add16(lost_count_q, seq_c_q - (rtp_seq_q + 16'd1));
        end
        if (fin_drop) begin
            state_d    = S_IDLE;
            pkt_drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            byte_cnt_q       <= '0;
            len_q            <= '0;
            seq_c_q          <= '0;
            ts_c_q           <= '0;
            hi_q             <= '0;
            ref_valid_q      <= 1'b0;
            wav_out_data_q   <= '0;
            wav_out_wren_q   <= 1'b0;
            rtp_seq_q        <= '0;
            rtp_timestamp_q  <= '0;
            pkt_ok_q         <= 1'b0;
            pkt_drop_q       <= 1'b0;
            lost_count_q     <= '0;
            overflow_count_q <= '0;
        end else begin
            state_q          <= state_d;
            byte_cnt_q       <= byte_cnt_d;
            len_q            <= len_d;
            seq_c_q          <= seq_c_d;
            ts_c_q           <= ts_c_d;
            hi_q             <= hi_d;
            ref_valid_q      <= ref_valid_d;
            wav_out_data_q   <= wav_out_data_d;
            wav_out_wren_q   <= wav_out_wren_d;
            rtp_seq_q        <= rtp_seq_d;
            rtp_timestamp_q  <= rtp_timestamp_d;
            pkt_ok_q         <= pkt_ok_d;
            pkt_drop_q       <= pkt_drop_d;
            lost_count_q     <= lost_count_d;
            overflow_count_q <= overflow_count_d;
        end
    end

    assign wav_out_data   = wav_out_data_q;
    assign wav_out_wren   = wav_out_wren_q;
    assign rtp_seq        = rtp_seq_q;
    assign rtp_timestamp  = rtp_timestamp_q;
    assign pkt_ok         = pkt_ok_q;
    assign pkt_drop       = pkt_drop_q;
    assign lost_count     = lost_count_q;
    assign overflow_count = overflow_count_q;

endmodule

// File: tb/tb_rtp_depacketizer.sv
// Scoreboard bench for rtp_depacketizer: directed packets push expected samples
// and packet results; a monitor pops and compares on every output strobe.
module tb_rtp_depacketizer;

    typedef struct {
        bit          ok;
        logic [15:0] seq;
        logic [31:0] ts;
        logic [15:0] lost;
        logic [15:0] ovf;
    } pkt_exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               udp_rec_data_valid;
    logic [7:0]         udp_rec_rdata;
    logic [15:0]        udp_rec_data_length;
    logic               wav_out_full;
    logic signed [15:0] wav_out_data;
    logic               wav_out_wren;
    logic [15:0]        rtp_seq;
    logic [31:0]        rtp_timestamp;
    logic               pkt_ok;
    logic               pkt_drop;
    logic [15:0]        lost_count;
    logic [15:0]        overflow_count;

    int checks   = 0;
    int failures = 0;

    logic [15:0] samp_q[$];
    pkt_exp_t    pkt_q[$];
    logic [7:0]  pkt[$];

    rtp_depacketizer dut (
        .clk                 (clk),
        .rst                 (rst),
        .udp_rec_data_valid  (udp_rec_data_valid),
        .udp_rec_rdata       (udp_rec_rdata),
        .udp_rec_data_length (udp_rec_data_length),
        .wav_out_full        (wav_out_full),
        .wav_out_data        (wav_out_data),
        .wav_out_wren        (wav_out_wren),
        .rtp_seq             (rtp_seq),
        .rtp_timestamp       (rtp_timestamp),
        .pkt_ok              (pkt_ok),
        .pkt_drop            (pkt_drop),
        .lost_count          (lost_count),
        .overflow_count      (overflow_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin
        pkt_exp_t e;
        logic [15:0] s;
        forever begin
            @(negedge clk);
            if (!rst && wav_out_wren) begin
                if (samp_q.size() == 0) begin
                    chk("unexpected_sample", {16'h0, wav_out_data}, 32'hFFFF_FFFF);
                end else begin
                    s = samp_q.pop_front();
                    chk("sample", {16'h0, wav_out_data}, {16'h0, s});
                end
            end
            if (!rst && (pkt_ok || pkt_drop)) begin
                if (pkt_q.size() == 0) begin
                    chk("unexpected_pkt_pulse", {30'h0, pkt_ok, pkt_drop}, 32'h0);
                end else begin
                    e = pkt_q.pop_front();
                    chk("pkt_ok", {31'h0, pkt_ok}, {31'h0, e.ok});
                    chk("pkt_drop", {31'h0, pkt_drop}, {31'h0, !e.ok});
                    chk("rtp_seq", {16'h0, rtp_seq}, {16'h0, e.seq});
                    chk("rtp_timestamp", rtp_timestamp, e.ts);
                    chk("lost_count", {16'h0, lost_count}, {16'h0, e.lost});
                    chk("overflow_count", {16'h0, overflow_count}, {16'h0, e.ovf});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic exp_samp(input logic [15:0] s);
        samp_q.push_back(s);
    endtask

    task automatic exp_pkt(input bit ok, input logic [15:0] seq, input logic [31:0] ts,
                           input logic [15:0] lost, input logic [15:0] ovf);
        pkt_exp_t e;
        e.ok = ok; e.seq = seq; e.ts = ts; e.lost = lost; e.ovf = ovf;
        pkt_q.push_back(e);
    endtask

    task automatic build_hdr(input logic [7:0] b0, input logic [7:0] b1, input logic [15:0] seq,
                             input logic [31:0] ts, input logic [31:0] ssrc);
        pkt.delete();
        pkt.push_back(b0);          pkt.push_back(b1);
        pkt.push_back(seq[15:8]);   pkt.push_back(seq[7:0]);
        pkt.push_back(ts[31:24]);   pkt.push_back(ts[23:16]);
        pkt.push_back(ts[15:8]);    pkt.push_back(ts[7:0]);
        pkt.push_back(ssrc[31:24]); pkt.push_back(ssrc[23:16]);
        pkt.push_back(ssrc[15:8]);  pkt.push_back(ssrc[7:0]);
    endtask

    // Drives n_send bytes of pkt; stays valid after the last byte so a following
    // send() runs back-to-back unless idle() is called in between.
    task automatic send(input logic [15:0] len, input int n_send, input int full_idx, input bit gaps);
        for (int i = 0; i < n_send; i++) begin
            @(posedge clk); #1;
            udp_rec_data_valid  = 1'b1;
            udp_rec_rdata       = pkt[i];
            udp_rec_data_length = (i == 0) ? len : 16'hDEAD;
            wav_out_full        = (i == full_idx);
            if (gaps && i != n_send - 1) begin
                @(posedge clk); #1;
                udp_rec_data_valid = 1'b0;
                wav_out_full       = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        udp_rec_data_valid = 1'b0;
        wav_out_full       = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        udp_rec_data_valid = 1'b0;
        wav_out_full       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wav_out_data", {16'h0, wav_out_data}, 32'h0);
        chk("rst_wren_ok_drop", {29'h0, wav_out_wren, pkt_ok, pkt_drop}, 32'h0);
        chk("rst_rtp_seq", {16'h0, rtp_seq}, 32'h0);
        chk("rst_rtp_timestamp", rtp_timestamp, 32'h0);
        chk("rst_lost_count", {16'h0, lost_count}, 32'h0);
        chk("rst_overflow_count", {16'h0, overflow_count}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst                 = 1'b1;
        udp_rec_data_valid  = 1'b0;
        udp_rec_rdata       = 8'h00;
        udp_rec_data_length = 16'h0;
        wav_out_full        = 1'b0;
        do_reset();
        idle(2);

        // Good len=16 packet, with idle gaps between bytes.
        build_hdr(8'h80, 8'h00, 16'h0005, 32'd100, 32'h12345678);
        pkt.push_back(8'h12); pkt.push_back(8'h34); pkt.push_back(8'hFE); pkt.push_back(8'hDC);
        exp_samp(16'h1234); exp_samp(16'hFEDC);
        exp_pkt(1, 16'h0005, 32'd100, 16'd0, 16'd0);
        send(16'd16, 16, -1, 1'b1);
        idle(3);

        // SSRC last byte wrong: dropped, no samples, seq unchanged.
        build_hdr(8'h80, 8'h00, 16'h0006, 32'd200, 32'h12345679);
        pkt.push_back(8'h11); pkt.push_back(8'h22); pkt.push_back(8'h33); pkt.push_back(8'h44);
        exp_pkt(0, 16'h0005, 32'd100, 16'd0, 16'd0);
        send(16'd16, 16, -1, 1'b0);
        idle(3);

        // Wrong payload type (marker bit alone would be ignored).
        build_hdr(8'h80, 8'h81, 16'h0006, 32'd200, 32'h12345678);
        pkt.push_back(8'h11); pkt.push_back(8'h22);
        exp_pkt(0, 16'h0005, 32'd100, 16'd0, 16'd0);
        send(16'd14, 14, -1, 1'b0);
        idle(2);

        // len=15 then len=5, then a good packet, all back-to-back.
        build_hdr(8'h80, 8'h00, 16'h0006, 32'd300, 32'h12345678);
        pkt.push_back(8'hAA); pkt.push_back(8'hBB); pkt.push_back(8'hCC);
        exp_pkt(0, 16'h0005, 32'd100, 16'd0, 16'd0);
        send(16'd15, 15, -1, 1'b0);
        build_hdr(8'h80, 8'h00, 16'h0006, 32'd300, 32'h12345678);
        exp_pkt(0, 16'h0005, 32'd100, 16'd0, 16'd0);
        send(16'd5, 5, -1, 1'b0);
        build_hdr(8'h80, 8'h00, 16'h0006, 32'd400, 32'h12345678);
        pkt.push_back(8'h80); pkt.push_back(8'h01);
        exp_samp(16'h8001);
        exp_pkt(1, 16'h0006, 32'd400, 16'd0, 16'd0);
        send(16'd14, 14, -1, 1'b0);
        idle(3);

        // Sequence wrap and gap from a fresh reference.
        do_reset();
        build_hdr(8'h80, 8'h00, 16'hFFFE, 32'h01020304, 32'h12345678);
        exp_pkt(1, 16'hFFFE, 32'h01020304, 16'd0, 16'd0);
        send(16'd12, 12, -1, 1'b0);
        build_hdr(8'h80, 8'h00, 16'hFFFF, 32'h01020305, 32'h12345678);
        exp_pkt(1, 16'hFFFF, 32'h01020305, 16'd0, 16'd0);
        send(16'd12, 12, -1, 1'b0);
        build_hdr(8'h80, 8'h00, 16'h0000, 32'h01020306, 32'h12345678);
        exp_pkt(1, 16'h0000, 32'h01020306, 16'd0, 16'd0);
        send(16'd12, 12, -1, 1'b0);
        build_hdr(8'h80, 8'h00, 16'h0003, 32'h01020307, 32'h12345678);
        exp_pkt(1, 16'h0003, 32'h01020307, 16'd2, 16'd0);
        send(16'd12, 12, -1, 1'b0);
        idle(3);

        // FIFO full on the low byte of the second sample.
        build_hdr(8'h80, 8'h00, 16'h0004, 32'hCAFEF00D, 32'h12345678);
        pkt.push_back(8'h11); pkt.push_back(8'h11); pkt.push_back(8'h22); pkt.push_back(8'h22);
        pkt.push_back(8'h33); pkt.push_back(8'h33); pkt.push_back(8'h44); pkt.push_back(8'h44);
        exp_samp(16'h1111); exp_samp(16'h3333); exp_samp(16'h4444);
        exp_pkt(1, 16'h0004, 32'hCAFEF00D, 16'd2, 16'd1);
        send(16'd20, 20, 15, 1'b0);
        idle(3);

        // Reset after payload byte 14 of a 20-byte packet; first sample still emits.
        build_hdr(8'h80, 8'h00, 16'h0050, 32'h00000777, 32'h12345678);
        for (int i = 0; i < 8; i++) pkt.push_back(8'h50 + 8'(i));
        exp_samp(16'h5051);
        send(16'd20, 15, -1, 1'b0);
        do_reset();
        build_hdr(8'h80, 8'h00, 16'h0100, 32'h00000888, 32'h12345678);
        exp_pkt(1, 16'h0100, 32'h00000888, 16'd0, 16'd0);
        send(16'd12, 12, -1, 1'b0);
        idle(5);

        chk("samples_left", samp_q.size(), 32'd0);
        chk("pkts_left", pkt_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
